// File: rtl/arb8_ctrl.sv
// arb8_ctrl: eight-requester fixed-priority / round-robin arbiter.
// Ports: clk, rst_n, en, req[7:0], rr_mode -> gnt, gnt_id, gnt_vld, timeout.
module arb8_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // A zero MAX_HOLD disables the hold limit entirely.
  localparam logic       HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [2:0] last;
  logic [7:0] hold_cnt;

  logic [2:0] fix_id;
  logic [2:0] rr_id;
  logic [2:0] idx;
  logic       found;
  logic [2:0] win;
  logic       hold_hit;
  logic       released;

  // Fixed: highest set index wins.
  always_comb begin
    fix_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) fix_id = 3'(i);
    end
  end

  // Round-robin: scan last+1 .. last+8, previous owner checked last.
  always_comb begin
    rr_id = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        rr_id = idx;
        found = 1'b1;
      end
    end
  end

  assign win      = rr_mode ? rr_id : fix_id;
  assign hold_hit = HOLD_EN && (hold_cnt == HOLD_LIM);
  assign released = !req[gnt_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 8'h00;
      gnt_id   <= 3'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      last     <= 3'd7;
      hold_cnt <= 8'd0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && |req) begin
            gnt      <= 8'h01 << win;
            gnt_id   <= win;
            gnt_vld  <= 1'b1;
            last     <= win;
            hold_cnt <= 8'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
          // Disable suppresses the timeout pulse; release does not.
          if (!en || hold_hit || released) begin
            state   <= IDLE;
            gnt     <= 8'h00;
            gnt_id  <= 3'd0;
            gnt_vld <= 1'b0;
            timeout <= en && hold_hit;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb8_ctrl.sv
// tb_arb8_ctrl: scoreboard bench for arb8_ctrl, MAX_HOLD = 4 and 0.
// Driver pushes model predictions; monitor pops and compares.
module tb_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rr_mode = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] g4, g0;
  logic [2:0] id4, id0;
  logic       v4, v0, t4, t0;

  arb8_ctrl #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .rr_mode(rr_mode), .gnt(g4), .gnt_id(id4),
    .gnt_vld(v4), .timeout(t4)
  );

  arb8_ctrl #(.MAX_HOLD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .rr_mode(rr_mode), .gnt(g0), .gnt_id(id0),
    .gnt_vld(v0), .timeout(t0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total = 0;

  int m_own[2];
  int m_held[2];
  int m_last[2];
  int m_to[2];
  int mh[2] = '{4, 0};

  task automatic chk(input string n, input logic [12:0] act,
                     input logic [12:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0t got gnt=%h id=%0d vld=%b to=%b want gnt=%h id=%0d vld=%b to=%b",
                  n, $time, act[12:5], act[4:2], act[1], act[0],
                  exp[12:5], exp[4:2], exp[1], exp[0]);
  endtask

  function automatic logic [12:0] pack_exp(input int k);
    logic [7:0] g;
    logic [2:0] id;
    g  = (m_own[k] >= 0) ? 8'(1 << m_own[k]) : 8'h00;
    id = (m_own[k] >= 0) ? 3'(m_own[k]) : 3'd0;
    return {g, id, 1'(m_own[k] >= 0), 1'(m_to[k])};
  endfunction

  function automatic int pick(input int k);
    if (rr_mode) begin
      for (int j = 1; j <= 8; j++) begin
        if (req[(m_last[k] + j) % 8]) return (m_last[k] + j) % 8;
      end
    end else begin
      for (int j = 7; j >= 0; j--) begin
        if (req[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_held[k] = 0;
      m_last[k] = 7;
      m_to[k]   = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 0;
      if (m_own[k] < 0) begin
        if (en && req != 8'h00) begin
          w = pick(k);
          m_own[k]  = w;
          m_held[k] = 1;
          m_last[k] = w;
        end
      end else if (!en) begin
        m_own[k] = -1;
      end else if (mh[k] != 0 && m_held[k] == mh[k]) begin
        m_own[k] = -1;
        m_to[k]  = 1;
      end else if (!req[m_own[k]]) begin
        m_own[k] = -1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic step(input logic rs, input logic e,
                      input logic [7:0] r, input logic m);
    @(negedge clk);
    rst_n   = rs;
    en      = e;
    req     = r;
    rr_mode = m;
    if (!rst_n) model_reset();
    else model_edge();
    sb.push_back({pack_exp(0), pack_exp(1)});
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_u4", {g4, id4, v4, t4}, 13'd0);
    chk("async_rst_u0", {g0, id0, v0, t0}, 13'd0);
    model_reset();
    sb.push_back({pack_exp(0), pack_exp(1)});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("u4", {g4, id4, v4, t4}, e.a);
        chk("u0", {g0, id0, v0, t0}, e.b);
      end
    end
  end

  initial begin
    logic [7:0] r;
    model_reset();
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // fixed priority and async reset mid-grant
    step(1, 1, 8'h81, 0);
    step(1, 1, 8'h81, 0);
    async_rst();
    step(0, 1, 8'h81, 0);
    step(1, 1, 8'h81, 0);
    step(1, 1, 8'h81, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h00, 0);

    // round-robin fairness, 2-cycle holds
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 28; i++) begin
      r = 8'hFF;
      if (m_own[0] >= 0 && m_held[0] == 2) r[m_own[0]] = 1'b0;
      step(1, 1, r, 1);
    end

    // timeout vs no-timeout
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 320; i++) step(1, 1, 8'h0C, 1);

    // enable
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h20, 0);
    step(1, 1, 8'h20, 0);
    step(1, 1, 8'h20, 0);
    step(1, 0, 8'h20, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'hFF, 0);
    step(1, 1, 8'hFF, 0);
    step(1, 1, 8'hFF, 0);
    step(1, 1, 8'h00, 0);

    // mode switch mid-grant
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h02, 0);
    step(1, 1, 8'h02, 0);
    step(1, 1, 8'h02, 1);
    step(1, 1, 8'h82, 1);
    step(1, 1, 8'h82, 1);
    step(1, 1, 8'h80, 1);
    step(1, 1, 8'h82, 1);
    step(1, 1, 8'h82, 1);
    step(1, 1, 8'h00, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_rst();
        step(0, 1, 8'(($urandom)), 1'($urandom));
      end else begin
        r = 8'($urandom);
        if (m_own[0] >= 0) r[m_own[0]] = ($urandom_range(0, 3) != 0);
        step(1, ($urandom_range(0, 15) != 0), r,
             ($urandom_range(0, 7) == 0) ? ~rr_mode : rr_mode);
      end
    end

    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h00, 0);
    @(posedge clk);
    #3;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain left=%0d want 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
